// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT sample loader: bank bookkeeping states and the
// write/FFT control FSM encodings.
package fft_pkg;

    localparam int unsigned SPI_WIDTH_DEF = 8;
    localparam int unsigned N_POINTS_DEF  = 32;
    localparam int unsigned ADDR_W        = $clog2(N_POINTS_DEF);

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankProcessing
    } bank_state_t;

    typedef enum logic {
        WrFill,
        WrHold
    } wr_state_t;

    typedef enum logic {
        FftIdle,
        FftBusy
    } fft_state_t;

endpackage

// File: rtl/spi_word_sync.sv
// Brings the sclk-domain word strobe into the clk domain and latches the SPI word on its
// rising edge, presenting a one-cycle word_valid pulse with the held word.
module spi_word_sync #(
    parameter int unsigned SPI_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 received_wd,
    input  logic [SPI_WIDTH-1:0] sample_in,
    output logic                 word_valid,
    output logic [SPI_WIDTH-1:0] word_data
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   valid_q, valid_d;
    logic [SPI_WIDTH-1:0]   data_q, data_d;
    logic                   rise;

    // sample_in is guaranteed stable for several sclk after the strobe, so it is safe to
    // capture it directly once the synchronized edge is seen.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], received_wd};
        rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        prev_d  = sync_q[SYNC_STAGES-1];
        valid_d = rise;
        data_d  = rise ? sample_in : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = data_q;

endmodule

// File: rtl/fft_sample_ctrl.sv
// Loads SPI samples into a two-bank ping-pong RAM, launches the FFT on each full bank and
// recycles banks as the FFT reports completion; words arriving with no free bank are dropped.
module fft_sample_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned SPI_WIDTH   = SPI_WIDTH_DEF,
    parameter int unsigned N_POINTS    = N_POINTS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        received_wd,
    input  logic [SPI_WIDTH-1:0]        sample_in,
    input  logic                        fft_done,
    output logic                        mem_we,
    output logic [$clog2(N_POINTS):0]   mem_waddr,
    output logic [SPI_WIDTH-1:0]        mem_wdata,
    output logic                        fft_start,
    output logic                        fft_bank,
    output logic                        fft_busy,
    output logic                        fft_start_posedge,
    output logic                        overflow
);

    localparam int unsigned IdxW = $clog2(N_POINTS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_POINTS - 1);

    logic                 word_valid;
    logic [SPI_WIDTH-1:0] word_data;

    wr_state_t            wr_state_q, wr_state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [IdxW-1:0]      wr_idx_q, wr_idx_d;
    bank_state_t [1:0]    bank_q, bank_d;
    logic                 first_full_q, first_full_d;
    fft_state_t           fft_state_q, fft_state_d;
    logic                 fft_bank_q, fft_bank_d;
    logic                 fft_start_q, fft_start_d;
    logic                 mem_we_q, mem_we_d;
    logic [IdxW:0]        mem_waddr_q, mem_waddr_d;
    logic [SPI_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                 overflow_q, overflow_d;

    logic acc_bank;
    logic accepting;
    logic other_free;
    logic freeing;
    logic pick;

    spi_word_sync #(
        .SPI_WIDTH  (SPI_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .received_wd(received_wd),
        .sample_in  (sample_in),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_bank_d    = wr_bank_q;
        wr_idx_d     = wr_idx_q;
        bank_d       = bank_q;
        first_full_d = first_full_q;
        fft_state_d  = fft_state_q;
        fft_bank_d   = fft_bank_q;
        fft_start_d  = 1'b0;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        overflow_d   = overflow_q;
        acc_bank     = wr_bank_q;
        accepting    = 1'b0;
        other_free   = 1'b0;
        pick         = 1'b0;
        freeing      = (fft_state_q == FftBusy) && fft_done;

        // HOLD resumes on bank state as registered, so a word in the resume cycle is kept.
        unique case (wr_state_q)
            WrFill: accepting = 1'b1;
            WrHold: begin
                if (bank_q[~wr_bank_q] == BankEmpty) begin
                    acc_bank   = ~wr_bank_q;
                    accepting  = 1'b1;
                    wr_bank_d  = ~wr_bank_q;
                    wr_state_d = WrFill;
                end
            end
            default: ;
        endcase

        if (word_valid) begin
            if (accepting) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = {acc_bank, wr_idx_q};
                mem_wdata_d = word_data;
                if (wr_idx_q == IdxLast) begin
                    bank_d[acc_bank] = BankFull;
                    wr_idx_d         = '0;
                    if (bank_q[~acc_bank] != BankFull) begin
                        first_full_d = acc_bank;
                    end
                    // A bank being released this very cycle counts as free.
                    other_free = (bank_q[~acc_bank] == BankEmpty) ||
                                 (freeing && (fft_bank_q == ~acc_bank));
                    if (other_free) begin
                        wr_bank_d = ~acc_bank;
                    end else begin
                        wr_state_d = WrHold;
                    end
                end else begin
                    bank_d[acc_bank] = BankFilling;
                    wr_idx_d         = wr_idx_q + IdxW'(1);
                end
            end else begin
                overflow_d = 1'b1;
            end
        end

        unique case (fft_state_q)
            FftIdle: begin
                if ((bank_q[0] == BankFull) || (bank_q[1] == BankFull)) begin
                    if ((bank_q[0] == BankFull) && (bank_q[1] == BankFull)) begin
                        pick = first_full_q;
                    end else begin
                        pick = (bank_q[1] == BankFull);
                    end
                    fft_start_d  = 1'b1;
                    fft_bank_d   = pick;
                    bank_d[pick] = BankProcessing;
                    fft_state_d  = FftBusy;
                end
            end
            FftBusy: begin
                if (fft_done) begin
                    bank_d[fft_bank_q] = BankEmpty;
                    fft_state_d        = FftIdle;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q   <= WrFill;
            wr_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            bank_q[0]    <= BankEmpty;
            bank_q[1]    <= BankEmpty;
            first_full_q <= 1'b0;
            fft_state_q  <= FftIdle;
            fft_bank_q   <= 1'b0;
            fft_start_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            bank_q       <= bank_d;
            first_full_q <= first_full_d;
            fft_state_q  <= fft_state_d;
            fft_bank_q   <= fft_bank_d;
            fft_start_q  <= fft_start_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem_we            = mem_we_q;
    assign mem_waddr         = mem_waddr_q;
    assign mem_wdata         = mem_wdata_q;
    assign fft_start         = fft_start_q;
    assign fft_start_posedge = fft_start_q;
    assign fft_bank          = fft_bank_q;
    assign fft_busy          = (fft_state_q == FftBusy);
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_fft_sample_ctrl.sv
// Directed bench for fft_sample_ctrl: a frame-level model of bank usage predicts every
// output each cycle, and literal checks after each scenario pin the model itself.
module tb_fft_sample_ctrl;

    localparam int N    = 32;
    localparam int S    = 2;
    localparam int WCYC = 128;  // one 8-bit SPI word at clk = 16x sclk
    localparam int HCYC = 16;   // strobe high for one sclk

    logic       clk = 1'b0;
    logic       reset_n;
    logic       received_wd;
    logic [7:0] sample_in;
    logic       fft_done;
    logic       mem_we;
    logic [5:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       fft_start;
    logic       fft_bank;
    logic       fft_busy;
    logic       fft_start_posedge;
    logic       overflow;

    fft_sample_ctrl #(
        .SPI_WIDTH  (8),
        .N_POINTS   (N),
        .SYNC_STAGES(S)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .received_wd      (received_wd),
        .sample_in        (sample_in),
        .fft_done         (fft_done),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .fft_start        (fft_start),
        .fft_bank         (fft_bank),
        .fft_busy         (fft_busy),
        .fft_start_posedge(fft_start_posedge),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: which banks hold full or in-flight frames, where the next word lands.
    bit         m_full [2];
    bit         m_proc [2];
    int         m_full_cyc [2];
    int         m_free_cyc [2];
    int         m_fullq [$];
    int         m_arr_cyc [$];
    logic [7:0] m_arr_dat [$];
    int         m_wr_bank, m_wr_idx, m_cur_bank, m_idle_from, m_drops;
    bit         m_holding, m_busy, m_ovf, m_prev_rwd;

    // Observed-output tallies used by the literal checks.
    int dut_we_cnt = 0, dut_start_cnt = 0, last_waddr = 0, last_we_cyc = 0;
    int last_start_bank = 0, last_start_cyc = 0, done_cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_proc[i] = 0; m_full_cyc[i] = 0; m_free_cyc[i] = -100;
        end
        m_fullq.delete(); m_arr_cyc.delete(); m_arr_dat.delete();
        m_wr_bank = 0; m_wr_idx = 0; m_cur_bank = 0; m_idle_from = 0;
        m_holding = 0; m_busy = 0; m_ovf = 0; m_prev_rwd = 0;
    endtask

    initial begin
        m_drops = 0;
        model_reset();
    end

    logic       e_we, e_start;
    int         e_addr, ob, b;
    logic [7:0] e_dat;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("reset mem_we", mem_we, 0);
            chk("reset mem_waddr", mem_waddr, 0);
            chk("reset fft_start", fft_start, 0);
            chk("reset fft_busy", fft_busy, 0);
            chk("reset fft_bank", fft_bank, 0);
            chk("reset overflow", overflow, 0);
            model_reset();
        end else begin
            e_we = 0; e_start = 0; e_addr = 0; e_dat = 0;
            if (!m_busy && cyc >= m_idle_from && m_fullq.size() > 0) begin
                if (m_full_cyc[m_fullq[0]] <= cyc - 1) begin
                    b = m_fullq.pop_front();
                    e_start = 1; m_busy = 1; m_cur_bank = b; m_full[b] = 0; m_proc[b] = 1;
                end
            end
            if (m_arr_cyc.size() > 0 && m_arr_cyc[0] == cyc) begin
                void'(m_arr_cyc.pop_front());
                e_dat = m_arr_dat.pop_front();
                if (m_holding) begin
                    ob = 1 - m_wr_bank;
                    if (!m_full[ob] && !m_proc[ob] && cyc >= m_free_cyc[ob] + 2) begin
                        m_holding = 0; m_wr_bank = ob;
                    end
                end
                if (m_holding) begin
                    m_ovf = 1; m_drops++;
                end else begin
                    e_we = 1; e_addr = m_wr_bank * N + m_wr_idx; m_wr_idx++;
                    if (m_wr_idx == N) begin
                        m_wr_idx = 0; m_full[m_wr_bank] = 1; m_full_cyc[m_wr_bank] = cyc;
                        m_fullq.push_back(m_wr_bank);
                        ob = 1 - m_wr_bank;
                        if (!m_full[ob] && !m_proc[ob]) m_wr_bank = ob;
                        else m_holding = 1;
                    end
                end
            end
            chk("mem_we", mem_we, e_we);
            if (e_we) begin
                chk("mem_waddr", mem_waddr, e_addr);
                chk("mem_wdata", mem_wdata, e_dat);
            end
            chk("fft_start", fft_start, e_start);
            chk("fft_start_posedge", fft_start_posedge, e_start);
            chk("fft_busy", fft_busy, m_busy);
            if (m_busy) chk("fft_bank", fft_bank, m_cur_bank);
            chk("overflow", overflow, m_ovf);
            if (fft_done && m_busy) begin
                m_busy = 0; m_proc[m_cur_bank] = 0; m_free_cyc[m_cur_bank] = cyc;
                m_idle_from = cyc + 2;
            end
            if (received_wd && !m_prev_rwd) begin
                m_arr_cyc.push_back(cyc + S + 2);
                m_arr_dat.push_back(sample_in);
            end
            m_prev_rwd = received_wd;
            if (mem_we) begin
                dut_we_cnt++; last_waddr = mem_waddr; last_we_cyc = cyc;
            end
            if (fft_start) begin
                dut_start_cnt++; last_start_bank = fft_bank; last_start_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [7:0] d, input bit done_at_write);
        @(posedge clk); #2;
        sample_in   = d;
        received_wd = 1'b1;
        for (int i = 1; i < WCYC; i++) begin
            @(posedge clk); #2;
            if (i == HCYC) received_wd = 1'b0;
            if (done_at_write && i == S + 2) begin
                fft_done = 1'b1; done_cyc = cyc;
            end
            if (done_at_write && i == S + 3) fft_done = 1'b0;
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #2;
        fft_done = 1'b1; done_cyc = cyc;
        @(posedge clk); #2;
        fft_done = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(4);
    endtask

    int b_we, b_st, b_dr;

    initial begin
        reset_n = 1'b0; received_wd = 1'b0; sample_in = '0; fft_done = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(4);

        // Frame 0 into bank 0
        b_we = dut_we_cnt; b_st = dut_start_cnt;
        for (int i = 0; i < 32; i++) send_word(8'(i), 1'b0);
        chk("t1 writes", dut_we_cnt - b_we, 32);
        chk("t1 last waddr", last_waddr, 31);
        chk("t1 starts", dut_start_cnt - b_st, 1);
        chk("t1 start bank", last_start_bank, 0);
        chk("t1 start latency", last_start_cyc - last_we_cyc, 1);

        // Frame 1 into bank 1 while bank 0 is processed
        b_we = dut_we_cnt; b_st = dut_start_cnt;
        for (int i = 32; i < 64; i++) send_word(8'(i), 1'b0);
        chk("t2 writes", dut_we_cnt - b_we, 32);
        chk("t2 last waddr", last_waddr, 63);
        chk("t2 no early start", dut_start_cnt - b_st, 0);
        chk("t2 busy", fft_busy, 1);
        pulse_done();
        idle(8);
        chk("t2 starts", dut_start_cnt - b_st, 1);
        chk("t2 start bank", last_start_bank, 1);
        chk("t2 start after done", last_start_cyc - done_cyc, 2);
        pulse_done();
        idle(8);
        chk("t2 idle after done", fft_busy, 0);

        // fft_done while idle
        b_st = dut_start_cnt;
        pulse_done();
        idle(8);
        chk("idle done starts", dut_start_cnt - b_st, 0);
        chk("idle done busy", fft_busy, 0);
        chk("idle done bank", fft_bank, 1);

        // Overflow: 96 words with no completion
        do_reset();
        b_we = dut_we_cnt; b_dr = m_drops;
        for (int i = 0; i < 96; i++) send_word(8'(i ^ 8'h5a), 1'b0);
        chk("t3 writes", dut_we_cnt - b_we, 64);
        chk("t3 drops", m_drops - b_dr, 32);
        chk("t3 overflow", overflow, 1);
        b_st = dut_start_cnt;
        pulse_done();
        idle(8);
        chk("t4 starts", dut_start_cnt - b_st, 1);
        chk("t4 start bank", last_start_bank, 1);
        b_we = dut_we_cnt;
        for (int i = 0; i < 3; i++) send_word(8'(8'ha0 + i), 1'b0);
        chk("t4 writes", dut_we_cnt - b_we, 3);
        chk("t4 last waddr", last_waddr, 2);
        chk("t4 overflow sticky", overflow, 1);

        // fft_done coinciding with the completing write of bank 1
        do_reset();
        b_we = dut_we_cnt; b_st = dut_start_cnt; b_dr = m_drops;
        for (int i = 0; i < 63; i++) send_word(8'(i + 3), 1'b0);
        send_word(8'hee, 1'b1);
        chk("t5 writes", dut_we_cnt - b_we, 64);
        chk("t5 starts", dut_start_cnt - b_st, 2);
        chk("t5 start bank", last_start_bank, 1);
        chk("t5 start after done", last_start_cyc - done_cyc, 2);
        send_word(8'h77, 1'b0);
        chk("t5 resume waddr", last_waddr, 0);
        chk("t5 drops", m_drops - b_dr, 0);
        chk("t5 overflow", overflow, 0);

        // Reset mid-fill discards the partial frame
        do_reset();
        for (int i = 0; i < 10; i++) send_word(8'(i + 100), 1'b0);
        do_reset();
        b_we = dut_we_cnt; b_st = dut_start_cnt;
        for (int i = 0; i < 32; i++) send_word(8'(i + 200), 1'b0);
        chk("t6 writes", dut_we_cnt - b_we, 32);
        chk("t6 last waddr", last_waddr, 31);
        chk("t6 starts", dut_start_cnt - b_st, 1);
        chk("t6 start bank", last_start_bank, 0);
        chk("t6 overflow", overflow, 0);

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
